serial_add_ctrl: RTL

//  Bit-serial adder sequencer: time-shares one external full-adder cell over WIDTH cycles.

---
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell for WIDTH cycles, LSB first,
// and collects the sum and final carry behind a start/ready/done handshake.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             accept;
   logic             last;

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      accept  = (state_q != StRun) && start;
      last    = (cnt_q == CntLast);

      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase

      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = b;
         carry_d = cin;
         cnt_d   = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
      end else if (state_q == StRun) begin
         // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
         sum_d   = {fa_s, sum_q[WIDTH-1:1]};
         carry_d = fa_cout;
         a_sh_d  = a_sh_q >> 1;
         b_sh_d  = b_sh_q >> 1;
         cnt_d   = cnt_q + CntW'(1);
         if (last) cout_d = fa_cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign ready  = (state_q != StRun);
   assign busy   = (state_q == StRun);
   assign done   = (state_q == StDone);
   assign sum    = sum_q;
   assign cout   = cout_q;
   assign fa_a   = busy & a_sh_q[0];
   assign fa_b   = busy & b_sh_q[0];
   assign fa_cin = busy & carry_q;

endmodule
